// File: rtl/floor_display_driver.sv
// floor_display_driver
//
// Drives the cabin/landing 7-segment floor indicator from the controller's
// binary floor number. The floor is latched on a one-cycle strobe. While the
// car is stopped the digit is steady. While it moves the digit blinks with
// phases of BLINK_CYCLES clocks each, and the direction lamps are lit.
// The segment encoding matches the one the display-decode path consumes, so
// the output can be looped back for self-check.
//
// Parameters:
//   BLINK_CYCLES  clock cycles per blink phase (on or off), must be >= 2
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   floor[3:0]   in   binary floor number (0-9 legal, others shown as a dash)
//   floor_valid  in   one-cycle strobe, latches floor
//   moving       in   car in motion (level)
//   up           in   direction while moving, 1 = up, 0 = down
//   display[6:0] out  segments g,f,e,d,c,b,a (bit6..bit0), active-high
//   dir_up       out  up-arrow lamp
//   dir_down     out  down-arrow lamp
//
// All outputs decode registered state only; no input reaches an output
// combinationally.

module floor_display_driver #(
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] floor,
    input  logic       floor_valid,
    input  logic       moving,
    input  logic       up,
    output logic [6:0] display,
    output logic       dir_up,
    output logic       dir_down
);

    // Guard keeps the width legal should someone instantiate with 1.
    localparam int unsigned CntW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StBlinkOn  = 2'd1,
        StBlinkOff = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]      cur_floor_q, cur_floor_d;
    logic            dir_q, dir_d;
    logic [6:0]      pattern;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            blink_cnt_q <= '0;
            cur_floor_q <= 4'd0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            cur_floor_q <= cur_floor_d;
            dir_q       <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        cur_floor_d = cur_floor_q;
        dir_d       = dir_q;

        // The floor latch is independent of the blink sequencer, so a
        // mid-blink update never disturbs phase timing.
        if (floor_valid) begin
            cur_floor_d = floor;
        end

        if (moving) begin
            dir_d = up;
        end

        case (state_q)
            StIdle: begin
                if (moving) begin
                    state_d     = StBlinkOn;
                    blink_cnt_d = '0;
                end
            end
            StBlinkOn, StBlinkOff: begin
                // Stopping wins over a phase toggle on the same edge.
                if (!moving) begin
                    state_d     = StIdle;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == CntMax) begin
                    state_d     = (state_q == StBlinkOn) ? StBlinkOff : StBlinkOn;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + CntOne;
                end
            end
            default: begin
                state_d     = StIdle;
                blink_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pattern = 7'b1000000;
        case (cur_floor_q)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = 7'b1000000; // dash flags an illegal floor
        endcase
    end

    always_comb begin
        display  = (state_q == StBlinkOff) ? 7'b0000000 : pattern;
        // Lamps stay lit through both blink phases.
        dir_up   = (state_q != StIdle) &  dir_q;
        dir_down = (state_q != StIdle) & ~dir_q;
    end

endmodule

// File: tb/tb_floor_display_driver.sv
module tb_floor_display_driver;

    localparam int BC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] floor = 4'd0;
    logic       floor_valid = 1'b0;
    logic       moving = 1'b0;
    logic       up = 1'b0;
    logic [6:0] display;
    logic       dir_up;
    logic       dir_down;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: floor shown, motion flag, cycles elapsed since motion
    // started. The digit is lit during even-numbered BC-long windows.
    int   m_floor = 0;
    bit   m_moving = 0;
    bit   m_dir = 0;
    int   m_t = 0;

    floor_display_driver #(.BLINK_CYCLES(BC)) dut (
        .clock       (clock),
        .reset       (reset),
        .floor       (floor),
        .floor_valid (floor_valid),
        .moving      (moving),
        .up          (up),
        .display     (display),
        .dir_up      (dir_up),
        .dir_down    (dir_down)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int f);
        case (f)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic bit lit_phase();
        return !m_moving || ((m_t / BC) % 2 == 0);
    endfunction

    function automatic bit off_phase_second_cycle();
        return m_moving && ((m_t / BC) % 2 == 1) && (m_t % BC == 1);
    endfunction

    task automatic check(input string tag);
        logic [6:0] e_disp;
        logic       e_up, e_dn;
        e_disp = lit_phase() ? seg(m_floor) : 7'b0000000;
        e_up   = m_moving & m_dir;
        e_dn   = m_moving & ~m_dir;
        vectors++;
        assert (display === e_disp) else begin
            miscompares++;
            $error("FAIL %s display got %b expected %b", tag, display, e_disp);
        end
        vectors++;
        assert (dir_up === e_up) else begin
            miscompares++;
            $error("FAIL %s dir_up got %b expected %b", tag, dir_up, e_up);
        end
        vectors++;
        assert (dir_down === e_dn) else begin
            miscompares++;
            $error("FAIL %s dir_down got %b expected %b", tag, dir_down, e_dn);
        end
    endtask

    // Apply inputs for one cycle, advance the model at the edge, then check.
    task automatic step(input logic r, input logic fv, input logic [3:0] fl,
                        input logic mv, input logic u, input string tag);
        reset = r; floor_valid = fv; floor = fl; moving = mv; up = u;
        @(posedge clock);
        if (r) begin
            m_floor = 0; m_moving = 0; m_dir = 0; m_t = 0;
        end else begin
            if (fv) m_floor = int'(fl);
            if (mv) m_dir = u;
            if (!m_moving && mv) begin
                m_moving = 1; m_t = 0;
            end else if (m_moving && !mv) begin
                m_moving = 0;
            end else if (m_moving) begin
                m_t++;
            end
        end
        #1;
        check(tag);
    endtask

    task automatic expect_literal(input string tag, input logic [6:0] want);
        vectors++;
        assert (display === want) else begin
            miscompares++;
            $error("FAIL %s display got %b expected %b", tag, display, want);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s timeout got no phase expected phase reached", tag);
    endtask

    initial begin
        int  n;
        bit  mv_r;

        // 1. Reset with random inputs, then release.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "reset");
        expect_literal("reset_lit", 7'b0111111);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), "release");

        // 2. Floor latch 0-9 and an illegal value.
        for (int f = 0; f <= 9; f++) begin
            step(1'b0, 1'b1, 4'(f), 1'b0, 1'b0, "latch");
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0, "latch_hold");
        end
        step(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, "latch_12");
        expect_literal("dash", 7'b1000000);

        // 3. Blink up from floor 3 across three full periods.
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, "latch_3");
        for (int i = 0; i < 6 * BC; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "blink_up");

        // 4. Stop on the 2nd cycle of an off phase, then restart.
        n = 0;
        while (!off_phase_second_cycle() && n < 4 * BC) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "seek_off");
            n++;
        end
        if (!off_phase_second_cycle()) timeout("stop_off");
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "stop_off");
        expect_literal("stop_off_lit", 7'b1001111);
        for (int i = 0; i < 3 * BC; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "restart");

        // 5. Moving down from floor 5, update to 4 during an off phase.
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, "latch_5");
        n = 0;
        do begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "seek_off2");
            n++;
        end while (!off_phase_second_cycle() && n < 4 * BC);
        if (!off_phase_second_cycle()) timeout("mid_blink");
        step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, "mid_blink_strobe");
        expect_literal("mid_blink_dark", 7'b0000000);
        for (int i = 0; i < 3 * BC; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "mid_blink");

        // 6. Reset in an on phase with floor 7 while moving.
        step(1'b0, 1'b1, 4'd7, 1'b1, 1'b1, "latch_7");
        n = 0;
        while (!(m_moving && lit_phase()) && n < 4 * BC) begin
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "seek_on");
            n++;
        end
        step(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, "reset_mid");
        expect_literal("reset_mid_lit", 7'b0111111);
        for (int i = 0; i < BC + 2; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "after_reset");

        // Randomised run; motion is sticky so full phases occur.
        mv_r = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) mv_r = ~mv_r;
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 5) == 0),
                 4'($urandom), mv_r, 1'($urandom_range(0, 7) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
